// File: rtl/dnn_mlp_pkg.sv
// Shared width arithmetic, weight-map helpers and output saturation for the MLP pipeline.
package dnn_mlp_pkg;

  function automatic int p1_w(input int x_w, input int w_w);
    return x_w + w_w;
  endfunction

  function automatic int h_w(input int p1, input int n_in);
    return p1 + $clog2(n_in);
  endfunction

  function automatic int p2_w(input int h, input int w_w);
    return h + w_w;
  endfunction

  function automatic int acc_w(input int p2, input int n_hid);
    return p2 + $clog2(n_hid);
  endfunction

  // First weight address belonging to layer 2.
  function automatic int l2_base(input int n_in, input int n_hid);
    return n_in * n_hid;
  endfunction

  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/dnn_mlp_pipe_if.sv
// Input vector, weight write and result handshakes of dnn_mlp_pipe.
interface dnn_mlp_pipe_if
  import dnn_mlp_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_HID = 4,
  parameter int N_OUT = 2,
  parameter int X_W   = 7,
  parameter int W_W   = 5,
  parameter int OUT_W = 21
);
  localparam int AW = $clog2(l2_base(N_IN, N_HID) + N_HID * N_OUT);

  logic                   in_valid;
  logic                   in_ready;
  logic [N_IN*X_W-1:0]    in_x;
  logic                   w_we;
  logic                   w_ready;
  logic [AW-1:0]          w_addr;
  logic [W_W-1:0]         w_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [N_OUT*OUT_W-1:0] out_y;

  modport master (
    output in_valid, in_x, w_we, w_addr, w_data, out_ready,
    input  in_ready, w_ready, out_valid, out_y
  );

  modport slave (
    input  in_valid, in_x, w_we, w_addr, w_data, out_ready,
    output in_ready, w_ready, out_valid, out_y
  );
endinterface

// File: rtl/dnn_dense_stage.sv
// One dense layer: registered product array followed by registered per-output sums.
module dnn_dense_stage
  import dnn_mlp_pkg::*;
#(
  parameter int FAN_IN  = 4,
  parameter int FAN_OUT = 4,
  parameter int A_W     = 7,
  parameter int B_W     = 5,
  parameter int S_W     = h_w(p1_w(A_W, B_W), FAN_IN)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         in_valid,
  input  logic [FAN_IN*A_W-1:0]        a,
  input  logic [FAN_IN*FAN_OUT*B_W-1:0] w,
  output logic                         mid_valid,
  output logic                         out_valid,
  output logic [FAN_OUT*S_W-1:0]       sum
);
  localparam int P_W = p1_w(A_W, B_W);

  logic [FAN_IN*FAN_OUT*P_W-1:0] prod_d;
  logic [FAN_IN*FAN_OUT*P_W-1:0] prod_q;
  logic [FAN_OUT*S_W-1:0]        sum_d;

  // Operands are sign-extended to the product width before multiplying.
  always_comb begin
    prod_d = '0;
    for (int i = 0; i < FAN_IN; i++) begin
      for (int j = 0; j < FAN_OUT; j++) begin
        prod_d[(i*FAN_OUT+j)*P_W +: P_W] = P_W'($signed(a[i*A_W +: A_W]))
                                         * P_W'($signed(w[(i*FAN_OUT+j)*B_W +: B_W]));
      end
    end
  end

  // NOTE: every combinational output is assigned a default first so no latch is inferred.
  always_comb begin
    logic signed [S_W-1:0] acc;
    acc   = '0;
    sum_d = '0;
    for (int j = 0; j < FAN_OUT; j++) begin
      acc = '0;
      for (int i = 0; i < FAN_IN; i++) begin
        acc = acc + S_W'($signed(prod_q[(i*FAN_OUT+j)*P_W +: P_W]));
      end
      sum_d[j*S_W +: S_W] = acc;
    end
  end

  // NOTE: state is updated with non-blocking assignments so all stages shift together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mid_valid <= 1'b0;
      out_valid <= 1'b0;
      prod_q    <= '0;
      sum       <= '0;
    end else if (en) begin
      mid_valid <= in_valid;
      prod_q    <= prod_d;
      out_valid <= mid_valid;
      sum       <= sum_d;
    end
  end
endmodule

// File: rtl/dnn_mlp_pipe.sv
// Pipelined dense/ReLU/dense MLP with loadable weights and valid/ready backpressure.
// Define DNN_MLP_OUT_SAT_EN to saturate results to OUT_W instead of wrapping.
module dnn_mlp_pipe
  import dnn_mlp_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_HID = 4,
  parameter int N_OUT = 2,
  parameter int X_W   = 7,
  parameter int W_W   = 5,
  parameter int OUT_W = 21
) (
  input  logic           clk,
  input  logic           rst,
  dnn_mlp_pipe_if.slave  bus
);
  localparam int P1_W    = p1_w(X_W, W_W);
  localparam int H_W     = h_w(P1_W, N_IN);
  localparam int P2_W    = p2_w(H_W, W_W);
  localparam int ACC_W   = acc_w(P2_W, N_HID);
  localparam int L2_BASE = l2_base(N_IN, N_HID);
  localparam int N_W     = L2_BASE + N_HID * N_OUT;
  localparam int AW      = $clog2(N_W);

  logic                    adv, accept, w_fire, pipe_empty;
  logic                    s0_valid, s1_valid, s2_valid, s3_valid, s4_valid;
  logic [N_IN*X_W-1:0]     s0_x;
  logic [N_HID*H_W-1:0]    acc1, h;
  logic [N_OUT*ACC_W-1:0]  acc2;
  logic [N_OUT*OUT_W-1:0]  y_d, out_y_q;
  logic                    out_valid_q;
  logic signed [W_W-1:0]   w_mem [N_W];
  logic [L2_BASE*W_W-1:0]  w1_flat;
  logic [N_HID*N_OUT*W_W-1:0] w2_flat;

  assign adv        = !out_valid_q || bus.out_ready;
  assign pipe_empty = !(s0_valid || s1_valid || s2_valid || s3_valid || s4_valid || out_valid_q);
  assign bus.in_ready  = adv && !bus.w_we;
  assign bus.w_ready   = pipe_empty;
  assign bus.out_valid = out_valid_q;
  assign bus.out_y     = out_y_q;
  assign accept = bus.in_valid && bus.in_ready;
  assign w_fire = bus.w_we && pipe_empty;

  // NOTE: the weight file is built from flops rather than RAM, so clearing it on reset is intended.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_W; i++) w_mem[i] <= '0;
    end else if (w_fire && ({1'b0, bus.w_addr} < (AW+1)'(N_W))) begin
      w_mem[bus.w_addr] <= bus.w_data;
    end
  end

  // Flat address order already matches the i*FAN_OUT+j layout of each dense stage.
  always_comb begin
    w1_flat = '0;
    w2_flat = '0;
    for (int i = 0; i < L2_BASE; i++) w1_flat[i*W_W +: W_W] = w_mem[i];
    for (int i = 0; i < N_HID*N_OUT; i++) w2_flat[i*W_W +: W_W] = w_mem[L2_BASE+i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid <= 1'b0;
      s0_x     <= '0;
    end else if (adv) begin
      s0_valid <= accept;
      if (accept) s0_x <= bus.in_x;
    end
  end

  dnn_dense_stage #(
    .FAN_IN(N_IN), .FAN_OUT(N_HID), .A_W(X_W), .B_W(W_W), .S_W(H_W)
  ) u_layer1 (
    .clk(clk), .rst(rst), .en(adv), .in_valid(s0_valid), .a(s0_x), .w(w1_flat),
    .mid_valid(s1_valid), .out_valid(s2_valid), .sum(acc1)
  );

  always_comb begin
    h = '0;
    for (int j = 0; j < N_HID; j++) begin
      h[j*H_W +: H_W] = acc1[j*H_W + H_W - 1] ? '0 : acc1[j*H_W +: H_W];
    end
  end

  dnn_dense_stage #(
    .FAN_IN(N_HID), .FAN_OUT(N_OUT), .A_W(H_W), .B_W(W_W), .S_W(ACC_W)
  ) u_layer2 (
    .clk(clk), .rst(rst), .en(adv), .in_valid(s2_valid), .a(h), .w(w2_flat),
    .mid_valid(s3_valid), .out_valid(s4_valid), .sum(acc2)
  );

  always_comb begin
    logic signed [ACC_W-1:0] acc_k;
    acc_k = '0;
    y_d   = '0;
    for (int k = 0; k < N_OUT; k++) begin
      acc_k = $signed(acc2[k*ACC_W +: ACC_W]);
`ifdef DNN_MLP_OUT_SAT_EN
      y_d[k*OUT_W +: OUT_W] = OUT_W'(sat(64'(acc_k), OUT_W));
`else
      y_d[k*OUT_W +: OUT_W] = OUT_W'(acc_k);
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
    end else if (adv) begin
      out_valid_q <= s4_valid;
      if (s4_valid) out_y_q <= y_d;
    end
  end
endmodule

// File: tb/tb_dnn_mlp_pipe.sv
// Directed self-checking bench for dnn_mlp_pipe, with a 16-bit-output twin in lock-step.
module tb_dnn_mlp_pipe;
  localparam int N_IN  = 4;
  localparam int N_HID = 4;
  localparam int N_OUT = 2;
  localparam int X_W   = 7;
  localparam int W_W   = 5;
  localparam int OUT_W = 21;
  localparam int OUT_N = 16;
  localparam int AW    = 5;
  localparam int N_W   = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  dnn_mlp_pipe_if #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .X_W(X_W), .W_W(W_W), .OUT_W(OUT_W)) bus ();
  dnn_mlp_pipe_if #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .X_W(X_W), .W_W(W_W), .OUT_W(OUT_N)) bus16 ();

  dnn_mlp_pipe #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .X_W(X_W), .W_W(W_W), .OUT_W(OUT_W))
    dut (.clk(clk), .rst(rst), .bus(bus));
  dnn_mlp_pipe #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .X_W(X_W), .W_W(W_W), .OUT_W(OUT_N))
    dut16 (.clk(clk), .rst(rst), .bus(bus16));

  assign bus16.in_valid  = bus.in_valid;
  assign bus16.in_x      = bus.in_x;
  assign bus16.w_we      = bus.w_we;
  assign bus16.w_addr    = bus.w_addr;
  assign bus16.w_data    = bus.w_data;
  assign bus16.out_ready = bus.out_ready;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic longint y_of(input int k);
    return longint'($signed(bus.out_y[k*OUT_W +: OUT_W]));
  endfunction

  function automatic longint y16_of(input int k);
    return longint'($signed(bus16.out_y[k*OUT_N +: OUT_N]));
  endfunction

  function automatic logic [N_IN*X_W-1:0] pack_x(input int a, input int b, input int c, input int d);
    return {X_W'(d), X_W'(c), X_W'(b), X_W'(a)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_w(input int a, input int d);
    int n;
    n = 0;
    bus.w_we   = 1'b1;
    bus.w_addr = AW'(a);
    bus.w_data = W_W'(d);
    #1;
    while (!bus.w_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check("w_ready_timeout", longint'(bus.w_ready), 1);
    tick();
    bus.w_we = 1'b0;
  endtask

  task automatic load(input int v1, input int v2);
    for (int a = 0; a < N_IN*N_HID; a++) write_w(a, v1);
    for (int a = N_IN*N_HID; a < N_W; a++) write_w(a, v2);
  endtask

  // Returns with the result on out_valid; lat counts edges after the accepting edge.
  task automatic send_one(input int a, input int b, input int c, input int d, output int lat);
    int n;
    n = 0;
    bus.in_x     = pack_x(a, b, c, d);
    bus.in_valid = 1'b1;
    #1;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int     lat, sent, recv, got, seen, n;
    logic   acc, held_v;
    longint held_y, e;

    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.w_we      = 1'b0;
    bus.w_addr    = '0;
    bus.w_data    = '0;
    bus.out_ready = 1'b1;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_y0", y_of(0), 0);
    check("rst_w_ready", bus.w_ready, 1);
    check("rst_in_ready", bus.in_ready, 1);
    rst = 1'b0;
    tick();

    // All weights 1, x=[1,2,3,4]: hidden 10, y=40
    load(1, 1);
    send_one(1, 2, 3, 4, lat);
    check("t1_latency", lat, 5);
    check("t1_y0", y_of(0), 40);
    check("t1_y1", y_of(1), 40);
    tick();
    check("t1_drained", bus.out_valid, 0);

    // Eight back-to-back vectors x=[r+1,r,-3,1] with a 4-cycle consumer stall
    sent = 0; recv = 0; held_v = 1'b0; held_y = 0;
    for (int c = 0; c < 80 && recv < 8; c++) begin
      bus.in_valid  = (sent < 8);
      bus.in_x      = pack_x(sent + 1, sent, -3, 1);
      bus.out_ready = !(c >= 7 && c < 11);
      #1;
      if (held_v) begin
        check("b2b_hold_valid", bus.out_valid, 1);
        check("b2b_hold_y0", y_of(0), held_y);
      end
      if (bus.out_valid && !bus.out_ready) check("b2b_stall_in_ready", bus.in_ready, 0);
      acc = bus.in_valid && bus.in_ready;
      if (bus.out_valid && bus.out_ready) begin
        e = (2*recv - 1 > 0) ? 4*(2*recv - 1) : 0;
        check("b2b_y0", y_of(0), e);
        check("b2b_y1", y_of(1), e);
        recv++;
      end
      held_v = bus.out_valid && !bus.out_ready;
      held_y = y_of(0);
      tick();
      if (acc) sent++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("b2b_count", recv, 8);
    tick();
    tick();
    check("b2b_no_dup", bus.out_valid, 0);

    // Weight writes while two vectors are in flight
    bus.in_x = pack_x(1, 2, 3, 4);
    bus.in_valid = 1'b1;
    #1;
    check("t5_in_ready_a", bus.in_ready, 1);
    tick();
    bus.in_x = pack_x(2, 0, 0, 0);
    tick();
    bus.in_valid = 1'b0;
    bus.w_we = 1'b1; bus.w_addr = AW'(1); bus.w_data = W_W'(-5);
    #1;
    check("t5_busy_w_ready", bus.w_ready, 0);
    check("t5_busy_in_ready", bus.in_ready, 0);
    tick();
    bus.w_we = 1'b0;
    tick();
    bus.w_we = 1'b1; bus.w_addr = AW'(0); bus.w_data = W_W'(2);
    #1;
    check("t5_hold_w_ready", bus.w_ready, 0);
    got = 0; n = 0;
    while (!bus.w_ready && n < 40) begin
      if (bus.out_valid) begin
        check("t5_drain_y0", y_of(0), got == 0 ? 40 : 8);
        got++;
      end
      tick();
      n++;
    end
    check("t5_drain_count", got, 2);
    check("t5_w_ready_after_drain", bus.w_ready, 1);
    tick();
    bus.w_we = 1'b0;
    // w1[0][0]=2, stray -5 to addr 1 must not have landed: h=[3,2,2,2], y=9
    send_one(1, 1, 0, 0, lat);
    check("t5_new_w_y0", y_of(0), 9);
    check("t5_new_w_y1", y_of(1), 9);
    tick();
    write_w(30, 7);
    send_one(1, 1, 0, 0, lat);
    check("t5_oob_y0", y_of(0), 9);
    check("t5_oob_y1", y_of(1), 9);
    tick();

    // w1=-1, w2=1: hidden -10 clipped by ReLU
    load(-1, 1);
    send_one(1, 2, 3, 4, lat);
    check("t2_y0", y_of(0), 0);
    check("t2_y1", y_of(1), 0);
    tick();

    // Extreme operands: y=-262144, 16-bit twin wraps or saturates
    load(-16, -16);
    send_one(-64, -64, -64, -64, lat);
    check("t4_latency", lat, 5);
    check("t4_y0", y_of(0), -262144);
    check("t4_y1", y_of(1), -262144);
`ifdef DNN_MLP_OUT_SAT_EN
    check("t4_y16_sat", y16_of(0), -32768);
`else
    check("t4_y16_wrap", y16_of(0), 0);
`endif
    tick();

    // Reset with three vectors in flight and the first one stalled at the output
    bus.out_ready = 1'b0;
    for (int v = 0; v < 3; v++) begin
      bus.in_x = pack_x(v, 1, 0, 0);
      bus.in_valid = 1'b1;
      #1;
      check("t6_in_ready", bus.in_ready, 1);
      tick();
    end
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    check("t6_stalled_valid", bus.out_valid, 1);
    rst = 1'b1;
    #1;
    check("t6_rst_out_valid", bus.out_valid, 0);
    check("t6_rst_out_y0", y_of(0), 0);
    check("t6_rst_w_ready", bus.w_ready, 1);
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.out_valid) seen++;
    end
    check("t6_no_stale", seen, 0);
    send_one(1, 2, 3, 4, lat);
    check("t6_latency", lat, 5);
    check("t6_y0", y_of(0), 0);
    check("t6_y1", y_of(1), 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
